voc_decoder: RTL
================

# voc_decoder

Receive-side companion to the vocoder frame stretcher. It accepts the stretched sample stream, in which each frame of SIZE samples is the first SIZE/2 samples followed by a repeat of them. It checks that the two halves match, and replays the SIZE/2 unique samples at half rate (one sample every second cycle). It sits at the consumer end of the vocoder link and restores the original sample cadence. It also flags duplicate mismatches and frame-sync errors.

## Interface
- SIZE, 8, samples per incoming frame; even, power of two, ≥ 4
- WIDTH, 3, sample width in bits
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  data_in holds a sample this cycle
- frame_start  in  1  qualified by in_valid; marks sample 0 of a frame
- data_in  in  WIDTH  incoming sample
- data_out  out  WIDTH  decoded sample; holds its value between pulses
- out_valid  out  1  one-cycle pulse per decoded sample
- dup_err  out  1  one-cycle pulse with the first out_valid of a frame whose halves mismatched
- sync_err  out  1  one-cycle pulse when a frame is aborted by an early frame_start

## Operation
- Storage: two banks of SIZE/2 × WIDTH, used ping-pong. The input side writes the fill bank; the output side reads the drain bank.
- Sample index counter `idx` is $clog2(SIZE) bits wide. It advances only on accepted samples (in_valid=1); gaps of any length are allowed.
- Input FSM has three states:
  - UNSYNC (reset state): all samples are ignored. A sample with frame_start=1 is stored as idx 0; the FSM moves to FIRST with idx=1.
  - FIRST: samples idx 0..SIZE/2-1 are written to fill[idx]. After idx SIZE/2-1 the FSM moves to SECOND.
  - SECOND: sample idx k is compared with fill[k-SIZE/2]. Any inequality sets the frame's sticky `mis` bit. Samples are not stored.
  - On accept of idx SIZE-1: the fill bank is handed to the drain side together with `mis`, the bank pointer toggles, `mis` clears, and the FSM returns to FIRST with idx=0. The next frame_start is optional: frame_start=1 at idx 0 is normal, frame_start=0 at idx 0 is also accepted.
- Early frame_start: frame_start=1 on an accepted sample while in FIRST/SECOND with idx≠0 does the following:
  - The partial frame is discarded and produces no output.
  - sync_err pulses for one cycle.
  - The sample is taken as idx 0 of a new frame in the same fill bank, and `mis` clears.
- Drain FSM has two states:
  - IDLE.
  - DRAIN: phase toggles every cycle. On each phase-0 cycle data_out ← drain[j] and out_valid pulses; j runs 0..SIZE/2-1. After j = SIZE/2-1 the FSM returns to IDLE.
- dup_err is the handed-over `mis`. It is asserted only in the cycle of the first out_valid of that frame.
- Overflow is impossible by construction. The minimum frame period is SIZE accepted cycles, which equals the drain duration, so a handoff never arrives while a drain is still in progress. Handoff and the final drain step may coincide on the same edge; the new drain must start without a gap.

## Timing
- Reset values: data_out=0, out_valid=0, dup_err=0, sync_err=0. Internal state after reset: UNSYNC, drain IDLE, idx=0, `mis`=0, bank pointer=0. Bank contents are don't-care.
- Reset mid-frame or mid-drain aborts everything immediately; no further out_valid is produced.
- Let the last sample (idx SIZE-1) be accepted at edge E. Then out_valid is high after edges E+1, E+3, …, E+SIZE-1, carrying samples 0..SIZE/2-1. Latency from last input to first output is 1 cycle.
- sync_err is registered: it is high in the cycle after the edge that accepted the offending frame_start.
- Back-to-back frames with in_valid continuously high give an uninterrupted output cadence of one out_valid every 2 cycles.

## Test plan
- Reset, then 8 contiguous samples 1,2,3,4,1,2,3,4 with frame_start on the first, last accepted at edge 7 → out_valid after edges 8,10,12,14 with data_out 1,2,3,4; dup_err=0; sync_err=0.
- Frame 5,6,7,0,5,6,7,1 → outputs 5,6,7,0 (first-half values); dup_err=1 only with the output of 5.
- Three frames back-to-back, no gaps, frame_start only on the first → 12 outputs, exactly every 2nd cycle, no gap at frame boundaries, correct order.
- Samples 3,3,3 before any frame_start are ignored. Then a frame with in_valid low on every other cycle → output starts 1 cycle after the last accepted sample; values correct.
- frame_start at idx 5 of a frame, followed by a clean frame 2,4,6,1,2,4,6,1 → sync_err one-cycle pulse; the aborted frame produces no outputs; outputs are 2,4,6,1.
- rst_n asserted low asynchronously between the 2nd and 3rd outputs of a drain → outputs go to 0 immediately; no further out_valid until a new synced frame completes.

Source files
------------

// File: rtl/voc_decoder_if.sv
// Sample-stream bundle for the vocoder receive path: stretched samples in,
// decoded samples and error pulses out.
interface voc_decoder_if #(
    parameter int WIDTH = 3
);
    logic             in_valid;
    logic             frame_start;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             dup_err;
    logic             sync_err;

    modport master (
        output in_valid, frame_start, data_in,
        input  data_out, out_valid, dup_err, sync_err
    );

    modport slave (
        input  in_valid, frame_start, data_in,
        output data_out, out_valid, dup_err, sync_err
    );
endinterface

// File: rtl/voc_decoder.sv
// Vocoder frame de-stretcher: verifies that the two halves of each frame agree and
// replays the first half at one sample every second cycle through ping-pong banks.
module voc_decoder #(
    parameter int SIZE  = 8,
    parameter int WIDTH = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    voc_decoder_if.slave  bus
);
    localparam int HALF = SIZE / 2;
    localparam int IW   = $clog2(SIZE);
    localparam int AW   = IW - 1;

    typedef enum logic [1:0] {UNSYNC, FIRST, SECOND} in_state_t;
    typedef enum logic       {IDLE, DRAIN}           dr_state_t;

    // Both banks share one array; the top address bit selects the bank.
    logic [WIDTH-1:0] mem [SIZE];

    in_state_t        state_reg, state_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic             mis_reg, mis_next;
    logic             bank_reg, bank_next;
    logic             sync_err_reg, sync_err_next;

    logic             wr_en;
    logic [IW-1:0]    wr_addr;
    logic             handoff;
    logic             handoff_mis;
    logic [WIDTH-1:0] cmp_word;
    logic [WIDTH-1:0] diff;
    logic             neq;

    dr_state_t        drain_reg, drain_next;
    logic             phase_reg, phase_next;
    logic [AW-1:0]    j_reg, j_next;
    logic             dbank_reg, dbank_next;
    logic             dmis_reg, dmis_next;
    logic [WIDTH-1:0] data_out_reg, data_out_next;
    logic             out_valid_reg, out_valid_next;
    logic             dup_err_reg, dup_err_next;

    // Second-half sample k lines up with first-half entry k-HALF, i.e. idx without its MSB.
    assign cmp_word = mem[{bank_reg, idx_reg[AW-1:0]}];

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cmp
        assign diff[gi] = bus.data_in[gi] ^ cmp_word[gi];
    end

    assign neq = |diff;

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        mis_next      = mis_reg;
        bank_next     = bank_reg;
        sync_err_next = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = {bank_reg, idx_reg[AW-1:0]};
        handoff       = 1'b0;
        handoff_mis   = 1'b0;
        if (bus.in_valid) begin
            if (state_reg == UNSYNC) begin
                if (bus.frame_start) begin
                    wr_en      = 1'b1;
                    wr_addr    = {bank_reg, {AW{1'b0}}};
                    idx_next   = IW'(1);
                    mis_next   = 1'b0;
                    state_next = FIRST;
                end
            end else if (bus.frame_start && (idx_reg != '0)) begin
                // Early frame_start: drop the partial frame and restart in the same bank.
                sync_err_next = 1'b1;
                wr_en         = 1'b1;
                wr_addr       = {bank_reg, {AW{1'b0}}};
                idx_next      = IW'(1);
                mis_next      = 1'b0;
                state_next    = FIRST;
            end else if (state_reg == FIRST) begin
                wr_en    = 1'b1;
                idx_next = idx_reg + IW'(1);
                if (idx_reg == IW'(HALF - 1)) begin
                    state_next = SECOND;
                end
            end else begin
                mis_next = mis_reg | neq;
                if (idx_reg == IW'(SIZE - 1)) begin
                    handoff     = 1'b1;
                    handoff_mis = mis_reg | neq;
                    bank_next   = ~bank_reg;
                    mis_next    = 1'b0;
                    idx_next    = '0;
                    state_next  = FIRST;
                end else begin
                    idx_next = idx_reg + IW'(1);
                end
            end
        end
    end

    always_comb begin
        drain_next     = drain_reg;
        phase_next     = phase_reg;
        j_next         = j_reg;
        dbank_next     = dbank_reg;
        dmis_next      = dmis_reg;
        data_out_next  = data_out_reg;
        out_valid_next = 1'b0;
        dup_err_next   = 1'b0;
        if (drain_reg == DRAIN) begin
            if (!phase_reg) begin
                data_out_next  = mem[{dbank_reg, j_reg}];
                out_valid_next = 1'b1;
                dup_err_next   = dmis_reg && (j_reg == '0);
                phase_next     = 1'b1;
            end else begin
                phase_next = 1'b0;
                if (j_reg == AW'(HALF - 1)) begin
                    drain_next = IDLE;
                end else begin
                    j_next = j_reg + AW'(1);
                end
            end
        end
        // A handoff can only land on the last drain cycle, so it simply restarts the drain.
        if (handoff) begin
            drain_next = DRAIN;
            phase_next = 1'b0;
            j_next     = '0;
            dbank_next = bank_reg;
            dmis_next  = handoff_mis;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= UNSYNC;
            idx_reg       <= '0;
            mis_reg       <= 1'b0;
            bank_reg      <= 1'b0;
            sync_err_reg  <= 1'b0;
            drain_reg     <= IDLE;
            phase_reg     <= 1'b0;
            j_reg         <= '0;
            dbank_reg     <= 1'b0;
            dmis_reg      <= 1'b0;
            data_out_reg  <= '0;
            out_valid_reg <= 1'b0;
            dup_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            mis_reg       <= mis_next;
            bank_reg      <= bank_next;
            sync_err_reg  <= sync_err_next;
            drain_reg     <= drain_next;
            phase_reg     <= phase_next;
            j_reg         <= j_next;
            dbank_reg     <= dbank_next;
            dmis_reg      <= dmis_next;
            data_out_reg  <= data_out_next;
            out_valid_reg <= out_valid_next;
            dup_err_reg   <= dup_err_next;
        end
    end

    assign bus.data_out  = data_out_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.dup_err   = dup_err_reg;
    assign bus.sync_err  = sync_err_reg;
endmodule
